gpio_irq_core: RTL and testbench
================================

GPIO_IRQ_CORE -- requirements
Module: gpio_irq_core

Interface
REQ-001 The block SHALL have parameter WIDTH_PORT, default 8, meaning the number of GPIO pins (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the input synchroniser depth (>=2).
REQ-003 The block SHALL have parameter DB_W, default 4, meaning the debounce counter width in bits.
REQ-004 The block SHALL have port clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetn_i  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port we_i  input  1  register write strobe, sampled on the clock edge.
REQ-007 The block SHALL have port addr_i  input  4  register address.
REQ-008 The block SHALL have port wdata_i  input  WIDTH_PORT  register write data.
REQ-009 The block SHALL have port rdata_o  output  WIDTH_PORT  combinational read data for addr_i.
REQ-010 The block SHALL have port irq_o  output  1  level interrupt, equal to OR of IRQ_STATUS.
REQ-011 The block SHALL have port gpio_io  inout  WIDTH_PORT  bidirectional pins.

Function
REQ-012 The register map SHALL be: 0 DIR rw (1=output); 1 OUT rw; 2 OUT_SET wo; 3 OUT_CLR wo; 4 OUT_TGL wo; 5 IN ro (debounced); 6 RISE_EN rw; 7 FALL_EN rw; 8 IRQ_STATUS rw1c; 9 DB_CNT rw (low DB_W bits, upper bits read 0).
REQ-013 Writes to OUT_SET/OUT_CLR/OUT_TGL SHALL update OUT on the same edge: OUT|wdata, OUT&~wdata, OUT^wdata; these addresses SHALL read 0.
REQ-014 Reads of addresses 10..15 SHALL return 0; writes to read-only or unmapped addresses SHALL be ignored.
REQ-015 Pin i SHALL be driven with OUT[i] when DIR[i]=1, else high-Z.
REQ-016 Each pin SHALL pass through a SYNC_STAGES flop chain; the synchronised value SHALL be sampled regardless of DIR (output readback).
REQ-017 Per pin, a DB_W-bit counter SHALL increment each cycle the synchronised value differs from IN[i] and clear to 0 when it matches.
REQ-018 On an edge where mismatch holds and counter==DB_CNT, IN[i] SHALL take the synchronised value and the counter SHALL clear.
REQ-019 Latency from a stable pin change to IN update SHALL be SYNC_STAGES+DB_CNT+1 cycles; DB_CNT=0 gives SYNC_STAGES+1.
REQ-020 A glitch shorter than DB_CNT+1 synchronised cycles SHALL not change IN or set status.
REQ-021 The counter SHALL not wrap: counter==DB_CNT always resolves, and DB_CNT=2^DB_W-1 SHALL be reachable.
REQ-022 On the edge IN[i] goes 0->1 with RISE_EN[i]=1, or 1->0 with FALL_EN[i]=1, IRQ_STATUS[i] SHALL set; both enables give both-edge detection.
REQ-023 Writing 1 to an IRQ_STATUS bit SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-024 If a set event and a W1C of the same bit coincide, set SHALL win.
REQ-025 Clearing RISE_EN/FALL_EN SHALL not clear already-set status bits.
REQ-026 irq_o SHALL be combinational OR of IRQ_STATUS, with no further gating.
REQ-027 A DB_CNT write SHALL take effect on the next cycle's comparisons; in-flight counters SHALL not be reset by it.

Reset
REQ-028 Asserting resetn_i low SHALL immediately clear DIR, OUT, RISE_EN, FALL_EN, IRQ_STATUS, DB_CNT, all sync flops, counters and IN to 0.
REQ-029 During and after reset all pins SHALL be high-Z and irq_o SHALL be 0.
REQ-030 Reset asserted mid-debounce or mid-write SHALL discard the operation; no status SHALL set on reset release even if pins are high.

Verification
REQ-031 DIR=0xFF, OUT=0x0F, write OUT_SET 0x30, OUT_CLR 0x01, OUT_TGL 0x81 -> gpio_io=0xBF, OUT reads 0xBF.
REQ-032 DIR=0x00, DB_CNT=0, pin0 0->1 -> IN[0]=1 exactly 3 cycles later (SYNC_STAGES=2); with RISE_EN=0x01, IRQ_STATUS=0x01 and irq_o=1 same cycle.
REQ-033 DB_CNT=5, pin1 pulse high 4 cycles -> IN stays 0x00, no status; pulse 6+ cycles -> IN[1]=1 at 8 cycles after pin edge.
REQ-034 RISE_EN=FALL_EN=0x04, pin2 toggles up then down -> status set each edge; W1C 0x04 same cycle as falling-edge set -> IRQ_STATUS[2] stays 1.
REQ-035 DIR=0x01, OUT=0x01, RISE_EN=0x01 -> readback IN[0]=1 and status set; assert resetn_i mid-run -> all registers 0, pins high-Z, irq_o=0, no status after release.

Source files
------------

// File: rtl/gpio_irq_core.sv
// rtl/gpio_irq_core.sv - GPIO block with per-pin synchroniser, debounce and edge interrupts
// Register file, tristate pin drivers, debounced input sampling and W1C interrupt status.
module gpio_irq_core #(
   parameter int WIDTH_PORT  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 4
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   input  logic                  we_i,
   input  logic [3:0]            addr_i,
   input  logic [WIDTH_PORT-1:0] wdata_i,
   output logic [WIDTH_PORT-1:0] rdata_o,
   output logic                  irq_o,
   inout  wire  [WIDTH_PORT-1:0] gpio_io
);

   localparam logic [3:0] A_DIR     = 4'd0;
   localparam logic [3:0] A_OUT     = 4'd1;
   localparam logic [3:0] A_OUT_SET = 4'd2;
   localparam logic [3:0] A_OUT_CLR = 4'd3;
   localparam logic [3:0] A_OUT_TGL = 4'd4;
   localparam logic [3:0] A_IN      = 4'd5;
   localparam logic [3:0] A_RISE_EN = 4'd6;
   localparam logic [3:0] A_FALL_EN = 4'd7;
   localparam logic [3:0] A_STATUS  = 4'd8;
   localparam logic [3:0] A_DB_CNT  = 4'd9;

   logic [WIDTH_PORT-1:0] r_dir;
   logic [WIDTH_PORT-1:0] r_out;
   logic [WIDTH_PORT-1:0] r_rise_en;
   logic [WIDTH_PORT-1:0] r_fall_en;
   logic [WIDTH_PORT-1:0] r_irq_status;
   logic [DB_W-1:0]       r_db_cnt;
   logic [WIDTH_PORT-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH_PORT-1:0] r_in;
   logic [DB_W-1:0]       r_cnt [WIDTH_PORT];

   logic [WIDTH_PORT-1:0] w_sync;
   logic [WIDTH_PORT-1:0] w_in_nxt;
   logic [WIDTH_PORT-1:0] w_upd;
   logic [WIDTH_PORT-1:0] w_set;
   logic [WIDTH_PORT-1:0] w_w1c;
   logic [DB_W-1:0]       w_cnt_nxt [WIDTH_PORT];

   for (genvar g = 0; g < WIDTH_PORT; g++) begin : g_pin
      assign gpio_io[g] = r_dir[g] ? r_out[g] : 1'bz;
   end

   // Pins are sampled whatever their direction so outputs read back through IN
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      end else begin
         r_sync[0] <= gpio_io;
         for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

   // ">=" keeps the counter from wrapping if DB_CNT is lowered below an in-flight count
   always_comb begin
      w_in_nxt = r_in;
      w_upd    = '0;
      for (int i = 0; i < WIDTH_PORT; i++) begin
         w_cnt_nxt[i] = '0;
         if (w_sync[i] != r_in[i]) begin
            if (r_cnt[i] >= r_db_cnt) begin
               w_in_nxt[i] = w_sync[i];
               w_upd[i]    = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign w_set = (w_upd & w_in_nxt & r_rise_en) | (w_upd & ~w_in_nxt & r_fall_en);
   assign w_w1c = (we_i && addr_i == A_STATUS) ? wdata_i : '0;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_in <= '0;
         for (int i = 0; i < WIDTH_PORT; i++) r_cnt[i] <= '0;
      end else begin
         r_in <= w_in_nxt;
         for (int i = 0; i < WIDTH_PORT; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_dir        <= '0;
         r_out        <= '0;
         r_rise_en    <= '0;
         r_fall_en    <= '0;
         r_db_cnt     <= '0;
         r_irq_status <= '0;
      end else begin
         // A set event on the same edge as its W1C wins
         r_irq_status <= (r_irq_status & ~w_w1c) | w_set;
         if (we_i) begin
            case (addr_i)
               A_DIR:     r_dir     <= wdata_i;
               A_OUT:     r_out     <= wdata_i;
               A_OUT_SET: r_out     <= r_out | wdata_i;
               A_OUT_CLR: r_out     <= r_out & ~wdata_i;
               A_OUT_TGL: r_out     <= r_out ^ wdata_i;
               A_RISE_EN: r_rise_en <= wdata_i;
               A_FALL_EN: r_fall_en <= wdata_i;
               A_DB_CNT:  r_db_cnt  <= wdata_i[DB_W-1:0];
               default:   ;
            endcase
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      case (addr_i)
         A_DIR:     rdata_o = r_dir;
         A_OUT:     rdata_o = r_out;
         A_IN:      rdata_o = r_in;
         A_RISE_EN: rdata_o = r_rise_en;
         A_FALL_EN: rdata_o = r_fall_en;
         A_STATUS:  rdata_o = r_irq_status;
         A_DB_CNT:  rdata_o[DB_W-1:0] = r_db_cnt;
         default:   rdata_o = '0;
      endcase
   end

   assign irq_o = |r_irq_status;

endmodule

// File: tb/tb_gpio_irq_core.sv
// tb/tb_gpio_irq_core.sv - scoreboard bench for gpio_irq_core
module tb_gpio_irq_core;

   logic       clk = 1'b0;
   logic       resetn;
   logic       we;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       irq;
   wire  [7:0] gpio;
   logic [7:0] tb_en;
   logic [7:0] tb_val;

   typedef struct {
      string      name;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 8; g++) begin : g_drv
      assign gpio[g] = tb_en[g] ? tb_val[g] : 1'bz;
   end

   gpio_irq_core #(.WIDTH_PORT(8), .SYNC_STAGES(2), .DB_W(4)) dut (
      .clk_i(clk), .resetn_i(resetn), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .rdata_o(rdata), .irq_o(irq), .gpio_io(gpio)
   );

   task automatic push(input string n, input logic [7:0] v);
      exp_t e;
      e.name = n;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk);
      we = 1'b0; addr = a;
      #1 d = rdata;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      exp_t e;
      for (int a = 0; a < 16; a++) push($sformatf("reset_reg%0d", a), 8'h00);
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         #1 got = rdata;
         e = sb.pop_front(); n_tests++;
         if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      end
      push("reset_irq", 8'h00);
      push("reset_pins_hiz", 8'hA5);
      got = {7'b0, irq};
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      got = gpio;
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      push("post_reset_in", 8'hA5);
      push("post_reset_status", 8'h00);
      rd(4'd5, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
   endtask

   task automatic test_regs();
      logic [7:0] got;
      logic [3:0] rd_addr [$];
      exp_t e;
      do_reset();
      wr(4'd0, 8'hFF);
      tb_en = 8'h00;
      wr(4'd1, 8'h0F);
      wr(4'd2, 8'h30);
      wr(4'd3, 8'h01);
      wr(4'd4, 8'h81);
      wr(4'd5, 8'h55);
      wr(4'd6, 8'hAA);
      wr(4'd7, 8'h55);
      wr(4'd9, 8'hFF);
      wr(4'd12, 8'hFF);
      repeat (4) @(negedge clk);
      push("out_reg", 8'hBF);      rd_addr.push_back(4'd1);
      push("dir_reg", 8'hFF);      rd_addr.push_back(4'd0);
      push("out_set_rd0", 8'h00);  rd_addr.push_back(4'd2);
      push("out_clr_rd0", 8'h00);  rd_addr.push_back(4'd3);
      push("out_tgl_rd0", 8'h00);  rd_addr.push_back(4'd4);
      push("in_readback", 8'hBF);  rd_addr.push_back(4'd5);
      push("rise_en", 8'hAA);      rd_addr.push_back(4'd6);
      push("fall_en", 8'h55);      rd_addr.push_back(4'd7);
      push("db_cnt_width", 8'h0F); rd_addr.push_back(4'd9);
      push("unmapped10", 8'h00);   rd_addr.push_back(4'd10);
      push("unmapped12", 8'h00);   rd_addr.push_back(4'd12);
      push("unmapped15", 8'h00);   rd_addr.push_back(4'd15);
      while (rd_addr.size() > 0) begin
         rd(rd_addr.pop_front(), got);
         e = sb.pop_front(); n_tests++;
         if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      end
      push("gpio_drive", 8'hBF);
      got = gpio;
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      tb_en = 8'hFF; tb_val = 8'h00;
      wr(4'd0, 8'h00);
   endtask

   task automatic test_latency();
      logic [7:0] got;
      exp_t e;
      do_reset();
      tb_en = 8'hFF; tb_val = 8'h00;
      wr(4'd6, 8'h01);
      @(negedge clk);
      tb_val = 8'h01; addr = 4'd5;
      for (int c = 1; c <= 3; c++) begin
         push($sformatf("lat_in_c%0d", c), (c == 3) ? 8'h01 : 8'h00);
         push($sformatf("lat_irq_c%0d", c), (c == 3) ? 8'h01 : 8'h00);
         @(negedge clk);
         #1 got = rdata;
         e = sb.pop_front(); n_tests++;
         if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
         got = {7'b0, irq};
         e = sb.pop_front(); n_tests++;
         if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      end
      push("lat_status", 8'h01);
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
   endtask

   task automatic test_debounce();
      logic [7:0] got;
      exp_t e;
      do_reset();
      tb_en = 8'hFF; tb_val = 8'h00;
      wr(4'd9, 8'h05);
      wr(4'd6, 8'h02);
      @(negedge clk);
      tb_val = 8'h02;
      repeat (4) @(negedge clk);
      tb_val = 8'h00;
      repeat (12) @(negedge clk);
      push("glitch_in", 8'h00);
      push("glitch_status", 8'h00);
      rd(4'd5, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      @(negedge clk);
      tb_val = 8'h02; addr = 4'd5;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c >= 7) begin
            push($sformatf("db_in_c%0d", c), (c == 8) ? 8'h02 : 8'h00);
            #1 got = rdata;
            e = sb.pop_front(); n_tests++;
            if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
         end
      end
      push("db_status", 8'h02);
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
   endtask

   task automatic test_both_edges();
      logic [7:0] got;
      exp_t e;
      do_reset();
      tb_en = 8'hFF; tb_val = 8'h00;
      wr(4'd6, 8'h04);
      wr(4'd7, 8'h04);
      @(negedge clk);
      tb_val = 8'h04;
      repeat (3) @(negedge clk);
      push("rise_status", 8'h04);
      push("w1c_zero_keeps", 8'h04);
      push("w1c_clears", 8'h00);
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      wr(4'd8, 8'h00);
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      wr(4'd8, 8'h04);
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      @(negedge clk);
      tb_val = 8'h00;
      repeat (2) @(negedge clk);
      we = 1'b1; addr = 4'd8; wdata = 8'h04;
      @(negedge clk);
      we = 1'b0;
      push("set_beats_w1c", 8'h04);
      push("set_beats_w1c_irq", 8'h01);
      #1 got = rdata;
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      got = {7'b0, irq};
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      wr(4'd6, 8'h00);
      wr(4'd7, 8'h00);
      push("en_clear_keeps", 8'h04);
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
   endtask

   task automatic test_reset_midrun();
      logic [7:0] got;
      exp_t e;
      do_reset();
      tb_en = 8'hFE; tb_val = 8'h00;
      wr(4'd0, 8'h01);
      wr(4'd1, 8'h01);
      wr(4'd6, 8'h01);
      repeat (4) @(negedge clk);
      push("rb_in", 8'h01);
      push("rb_status", 8'h01);
      rd(4'd5, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      push("mid_reset_irq", 8'h00);
      got = {7'b0, irq};
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      for (int a = 0; a < 10; a++) push($sformatf("mid_reset_reg%0d", a), 8'h00);
      for (int a = 0; a < 10; a++) begin
         addr = 4'(a);
         #1 got = rdata;
         e = sb.pop_front(); n_tests++;
         if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      end
      tb_en = 8'hFF; tb_val = 8'h00;
      #1;
      push("mid_reset_pins_hiz", 8'h00);
      got = gpio;
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      tb_val = 8'hFF;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (10) @(negedge clk);
      push("release_status", 8'h00);
      push("release_in", 8'hFF);
      push("release_irq", 8'h00);
      rd(4'd8, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      rd(4'd5, got);
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
      got = {7'b0, irq};
      e = sb.pop_front(); n_tests++;
      if (got !== e.val) begin $display("FAIL %s got=%h exp=%h", e.name, got, e.val); n_fail++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; we = 1'b0; addr = 4'd0; wdata = 8'h00;
      tb_en = 8'hFF; tb_val = 8'hA5;
      repeat (2) @(negedge clk);
      test_reset();
      test_regs();
      test_latency();
      test_debounce();
      test_both_edges();
      test_reset_midrun();
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
         n_fail++;
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
